// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types, default rates and helper functions for the UART receive path.
//
// Contents:
//   UART_DATA_BITS / UART_CLK_RATE / UART_BAUD_RATE : default frame width and
//     rates, shared with the transmitter so both ends agree out of the box.
//   uart_rx_state_t : receiver FSM state encoding.
//   even_parity()   : XOR-reduction used to check the even-parity bit.
//
// Build option: UART_RX_PARITY_EN (consumed by uart_rx, not by this package).

package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLK_RATE  = 153600;
  localparam int UART_BAUD_RATE = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  // Returns 1 when the vector holds an odd number of ones. Applied to
  // {data, parity bit}, a result of 1 means even parity was violated.
  // Narrower vectors are zero-extended by the caller; zeros do not change
  // the result.
  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and flags the
// idle-to-start transition.
//
// Ports:
//   clk   in   receiver clock, rising edge
//   rst_n in   asynchronous active-low reset
//   rx    in   raw serial line, idle high, asynchronous to clk
//   rx_s  out  synchronized line (two flops behind rx)
//   fall  out  one-cycle strobe when rx_s goes 1 -> 0
//
// All flops reset to 1 so that releasing reset onto an idle line can never
// look like a start edge.

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;

  // Requires a 1 before the 0, so a line that stays low cannot re-arm.
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: one start bit, DATA data bits (MSB first), optional even
// parity bit, one stop bit. The line is oversampled at OSR = CLK_RATE/BAUD_RATE
// clocks per bit and each bit is taken at its midpoint. Received words are
// held with their error flags until the consumer acknowledges them.
//
// Parameters:
//   DATA      data bits per frame (>= 2)
//   CLK_RATE  clock frequency in Hz
//   BAUD_RATE line rate in baud; CLK_RATE/BAUD_RATE must be even and >= 4
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   rx_ack     in   consumer accepts the held word
//   rx_data    out  last received word
//   rx_valid   out  rx_data and flags valid, held until acked
//   parity_err out  parity mismatch on the held word
//   frame_err  out  stop bit sampled low on the held word
//   overrun    out  a word was overwritten before being acked
//   busy       out  high in every state except IDLE
//
// Build option:
//   UART_RX_PARITY_EN  defined: frame carries an even-parity bit after the
//                      data and the PARITY state is used.
//                      undefined: no parity bit, parity_err stays 0.
//   Must match the transmitter build.

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA      = UART_DATA_BITS,
  parameter int CLK_RATE  = UART_CLK_RATE,
  parameter int BAUD_RATE = UART_BAUD_RATE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            rx_ack,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  localparam int OSR = CLK_RATE / BAUD_RATE;
  localparam int OSW = $clog2(OSR);
  localparam int BCW = $clog2(DATA);

  // The START check lands in the middle of the start bit; every later bit
  // is then one full bit period away, which keeps sampling at midpoints.
  localparam logic [OSW-1:0] OS_MID   = OSW'(OSR / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OSR - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  // Frame FSM and its datapath.
  uart_rx_state_t  state_q,   state_d;
  logic [OSW-1:0]  os_cnt_q,  os_cnt_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA-1:0] shift_q,   shift_d;

  // Held word and flags.
  logic [DATA-1:0] rx_data_q,    rx_data_d;
  logic            rx_valid_q,   rx_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q,  frame_err_d;
  logic            overrun_q,    overrun_d;

  // Output-decode strobes.
  logic load;
  logic busy_c;
  logic parity_calc;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_calc = even_parity(64'({shift_q, par_q}));
`else
  assign parity_calc = 1'b0;
`endif

  // State register for the frame FSM and its counters/shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic. The oversample counter free-runs inside a bit and is
  // cleared whenever a bit boundary (or the start midpoint) is reached.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q + OSW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end

      START: begin
        if (os_cnt_q == OS_MID) begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          // A line back high at mid-start was a glitch, not a frame.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = uart_pkg::DATA;
          end
        end
      end

      uart_pkg::DATA: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          shift_d  = {shift_q[DATA-2:0], rx_s};
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          par_d    = rx_s;
          state_d  = STOP;
        end
      end
`endif

      STOP: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          state_d  = IDLE;
        end
      end

      default: begin
        os_cnt_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy_c = (state_q != IDLE);
    load   = (state_q == STOP) && (os_cnt_q == OS_LAST);
  end

  // Held-word update. A load always wins over an acknowledge; an ack that
  // coincides with a load counts as consuming the old word, so no overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (load) begin
      rx_data_d    = shift_q;
      parity_err_d = parity_calc;
      frame_err_d  = ~rx_s;
      overrun_d    = rx_valid_q & ~rx_ack;
      rx_valid_d   = 1'b1;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_c;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx at the default rates (OSR = 16, 8 data bits).
// Frames are driven on the pin one bit per 16 clocks; outputs are sampled
// 1 ns after a rising edge or on the falling edge. A falling-edge monitor
// records when busy and rx_valid change so frame latency can be checked.
// Honours UART_RX_PARITY_EN the same way as the design.

module tb_uart_rx;

  localparam int OSR = 16;

`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
  localparam int LAT    = 168;
`else
  localparam int PAR_EN = 0;
  localparam int LAT    = 152;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;
  int cyc;
  int pinFallCyc;
  int busyRiseCyc;
  int busyFallCyc;
  int validRiseCyc;
  int busyRises;
  int savedRises;
  logic busyPrev;
  logic validPrev;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge count used as the time base for latency checks.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Records busy/rx_valid transitions away from the active edge.
  initial begin
    busyPrev     = 1'b0;
    validPrev    = 1'b0;
    busyRises    = 0;
    busyRiseCyc  = 0;
    busyFallCyc  = 0;
    validRiseCyc = 0;
  end

  always @(negedge clk) begin
    if (busy && !busyPrev) begin
      busyRiseCyc = cyc;
      busyRises   = busyRises + 1;
    end
    if (!busy && busyPrev) busyFallCyc = cyc;
    if (rx_valid && !validPrev) validRiseCyc = cyc;
    busyPrev  = busy;
    validPrev = rx_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Must be called 1 ns after a rising edge; returns at the same phase.
  task automatic driveBit(input logic v);
    rx = v;
    repeat (OSR) @(posedge clk);
    #1;
  endtask

  // Sends one complete frame; badParity inverts the parity bit.
  task automatic applyStimulus(input logic [7:0] data, input logic badParity,
                               input logic stopBit);
    @(posedge clk);
    #1;
    pinFallCyc = cyc;
    driveBit(1'b0);
    for (int i = 7; i >= 0; i--) driveBit(data[i]);
    if (PAR_EN != 0) driveBit((^data) ^ badParity);
    driveBit(stopBit);
  endtask

  task automatic ackPulse();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input logic [7:0] data, input logic v,
                            input logic pe, input logic fe, input logic ov);
    checkOutput({tag, "_data"},   32'(rx_data),   32'(data));
    checkOutput({tag, "_valid"},  32'(rx_valid),  32'(v));
    checkOutput({tag, "_parity"}, 32'(parity_err), 32'(pe));
    checkOutput({tag, "_frame"},  32'(frame_err), 32'(fe));
    checkOutput({tag, "_overrun"}, 32'(overrun),  32'(ov));
    checkOutput({tag, "_busy"},   32'(busy),      32'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkFlags("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] 0xA5 good frame");
    applyStimulus(8'hA5, 1'b0, 1'b1);
    checkFlags("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_start_delay", busyRiseCyc - pinFallCyc, 3);
    checkOutput("a5_latency", busyFallCyc - busyRiseCyc, LAT);
    checkOutput("a5_valid_with_idle", validRiseCyc - busyRiseCyc, LAT);
    ackPulse();
    checkOutput("a5_ack_valid", 32'(rx_valid), 0);
    ackPulse();
    checkOutput("idle_ack_ignored", 32'(rx_valid), 0);

    $display("[TB] 0x3C bad parity");
    applyStimulus(8'h3C, 1'b1, 1'b1);
    checkFlags("3c", 8'h3C, 1'b1, PAR_EN[0], 1'b0, 1'b0);
    ackPulse();

    $display("[TB] 0x81 low stop bit");
    applyStimulus(8'h81, 1'b0, 1'b0);
    checkFlags("81", 8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
    savedRises = busyRises;
    repeat (40) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("81_no_rearm", busyRises, savedRises);
    checkOutput("81_busy_idle", 32'(busy), 0);
    ackPulse();

    $display("[TB] false start");
    savedRises = busyRises;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("false_busy_pulse", busyRises, savedRises + 1);
    checkOutput("false_busy_width", busyFallCyc - busyRiseCyc, OSR / 2);
    checkOutput("false_busy_idle", 32'(busy), 0);
    checkOutput("false_valid", 32'(rx_valid), 0);

    $display("[TB] back-to-back overrun");
    applyStimulus(8'h11, 1'b0, 1'b1);
    checkOutput("b2b_first", 32'(rx_data), 32'h11);
    applyStimulus(8'h22, 1'b0, 1'b1);
    checkFlags("b2b", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_latency", busyFallCyc - busyRiseCyc, LAT);
    ackPulse();
    checkOutput("b2b_ack_valid", 32'(rx_valid), 0);
    checkOutput("b2b_ack_overrun", 32'(overrun), 0);

    $display("[TB] ack coincident with load");
    applyStimulus(8'h33, 1'b0, 1'b1);
    fork
      applyStimulus(8'h44, 1'b0, 1'b1);
      begin
        wait (rx === 1'b0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
      end
    join
    checkFlags("ackload", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    ackPulse();

    $display("[TB] reset mid-frame");
    applyStimulus(8'h77, 1'b0, 1'b1);
    checkOutput("pre_reset_data", 32'(rx_data), 32'h77);
    @(posedge clk);
    #1;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput("mid_frame_busy", 32'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkFlags("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 32'(busy), 0);
    applyStimulus(8'h5A, 1'b0, 1'b1);
    checkFlags("5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("5a_latency", busyFallCyc - busyRiseCyc, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the team's UART link: recovers frames of one start bit, DATA data bits (MSB first), an optional even-parity bit and one stop bit from the `rx` line. It oversamples at CLK_RATE/BAUD_RATE (16x by default) and samples each bit at its midpoint. It presents each received word with error flags through a valid/ack handshake. It pairs with the team's UART transmitter and uses the same default rates.

## Interface
- DATA, 8: data bits per frame
- CLK_RATE, 153600: clock frequency, Hz
- BAUD_RATE, 9600: line rate, baud
- OSR (localparam): CLK_RATE/BAUD_RATE; must be even and >= 4
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx  in  1  serial line; idle high; asynchronous to clk
- rx_ack  in  1  consumer accepts the held word
- rx_data  out  DATA  last received word
- rx_valid  out  1  rx_data and flags are valid; held until acked
- parity_err  out  1  parity mismatch on the held word
- frame_err  out  1  stop bit sampled low on the held word
- overrun  out  1  a word was overwritten before being acked
- busy  out  1  high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchronizer to give rx_s. The synchronizer flops reset to 1.
- A falling edge on rx_s (previous 1, current 0) arms reception from IDLE only. A line held low never re-arms.
- States: IDLE, START, DATA, PARITY, STOP. os_cnt is [$clog2(OSR)-1:0]; bit_cnt is [$clog2(DATA)-1:0].
- IDLE -> START on a falling edge; os_cnt=0.
- START: os_cnt increments. At os_cnt==OSR/2-1:
  - rx_s==0 -> DATA; os_cnt=0, bit_cnt=0.
  - rx_s==1 -> IDLE (false start; no output change).
- DATA: at os_cnt==OSR-1, shift rx_s into the shift register MSB first and set os_cnt=0.
  - bit_cnt==DATA-1 -> PARITY (or STOP without parity).
  - otherwise bit_cnt++.
- PARITY: at os_cnt==OSR-1, capture the parity bit -> STOP.
- STOP: at os_cnt==OSR-1, on the next edge:
  - rx_data <= shift register.
  - parity_err <= ^{data, parity bit}.
  - frame_err <= ~rx_s.
  - overrun <= rx_valid & ~rx_ack.
  - rx_valid <= 1.
  - -> IDLE.
- A word with frame_err is still delivered.
- Handshake:
  - rx_ack while rx_valid clears rx_valid and overrun on the next edge.
  - rx_ack while rx_valid is low is ignored.
  - rx_ack on the same cycle as a load: the new word loads, rx_valid stays 1, overrun=0.
- Reset mid-frame: all state goes to IDLE and the partial word is discarded. A fresh falling edge is needed after release.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - State IDLE; counters 0.
- START is entered 3 edges after `rx` falls at the pin (2 for the synchronizer, 1 for edge detect).
- Let t0 be the START entry cycle. rx_valid rises at t0 + OSR/2 + (DATA+2)*OSR with parity, or t0 + OSR/2 + (DATA+1)*OSR without.
  - Defaults: 168 cycles with parity, 152 without.
- Bit k (0 = first data bit) is sampled at t0 + OSR/2 + (k+1)*OSR - 1.
- IDLE accepts a new start edge on the cycle after STOP completes. Back-to-back frames are received with no gap cycles.
- busy is low in IDLE only; it deasserts on the same edge rx_valid asserts.

## Configuration
- UART_RX_PARITY_EN defined: the frame carries the even-parity bit after the data, and the PARITY state is used.
- UART_RX_PARITY_EN undefined:
  - The PARITY state is removed; DATA goes directly to STOP.
  - parity_err is tied 0.
  - The frame is one bit shorter.
- Must match the transmitter build.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Function even_parity().
  - Default rate constants.
- Sub-module uart_rx_sync contains the 2-flop synchronizer (reset to 1) plus the falling-edge detect. It outputs rx_s and fall.

## Test plan
- Send 0xA5 with correct parity (1'b0) and a high stop bit -> at cycle 168 after START, rx_data=0xA5 and rx_valid=1; parity_err, frame_err and overrun all 0; busy low.
- Send 0x3C with the parity bit inverted -> rx_data=0x3C, parity_err=1, frame_err=0.
- Send 0x81 with the stop bit low, holding the line low for 40 cycles -> rx_data=0x81, frame_err=1; no second frame until the line returns high and falls again.
- Pull `rx` low for 4 clocks, then high -> false start; busy pulses, state returns to IDLE, rx_valid stays 0.
- Send 0x11 then 0x22 back-to-back with no rx_ack -> rx_data=0x22, overrun=1. One rx_ack cycle -> rx_valid=0 and overrun=0 on the next edge.
- Assert rst_n low in the middle of the DATA state of 0xFF -> all outputs 0 immediately. Then send 0x5A -> rx_data=0x5A, no errors. Rerun the whole suite without UART_RX_PARITY_EN and check the 152-cycle latency.
